shm_dma_engine: RTL and testbench
=================================

SHM_DMA_ENGINE -- requirements
Module: shm_dma_engine

Interface
REQ-001 The block SHALL have parameter PROC_CNT, default 4, number of processor channels (at least 2).
REQ-002 The block SHALL have parameter SHM_AW, default 8, shared-memory word-address width.
REQ-003 The block SHALL have parameter LOC_AW, default 4, processor local-memory address width.
REQ-004 The block SHALL have parameter WORD_SIZE, default 16, data width.
REQ-005 The block SHALL have parameter PAGE_SIZE, default 2, log2 of words per page (at least 1); PAGES_AW = SHM_AW - PAGE_SIZE.
REQ-006 The block SHALL have one clock and a synchronous active-high reset, with these ports (name, direction, width, meaning):
- clock in 1: sole clock, rising edge.
- reset in 1: synchronous, active-high.
- req_toggle in PROC_CNT: per-channel request toggle.
- req_write in PROC_CNT: 1 = STORE (local to shm), 0 = LOAD.
- req_ptr in PROC_CNT x SHM_AW: shm start word address.
- req_local in PROC_CNT x LOC_AW: local start address.
- req_len in PROC_CNT x (LOC_AW+1): word count.
- ack_toggle out PROC_CNT: completion toggle.
- pm_addr, pm_wdata, pm_we out, per channel: local memory port; pm_rdata in, per channel.
- cn_addr out SHM_AW, cn_wdata out WORD_SIZE, cn_we out 1: content RAM port; cn_rdata in WORD_SIZE.
- pl_addr out PAGES_AW: page-list address; pl_rdata in PAGES_AW: next page of the addressed page.
- busy out 1: a transfer is active.
- err out 1: sticky chain-overrun flag (only when the Configuration macro is defined).
REQ-007 All attached RAMs SHALL have 1-cycle synchronous read latency.

Function
REQ-008 Channel i SHALL be pending while req_toggle[i] != ack_toggle[i].
REQ-009 In IDLE, the block SHALL grant the first pending channel after the last-served channel (round-robin with wrap) and latch that channel's req_* fields at the grant.
- The last-served channel resets to PROC_CNT-1.
REQ-010 The FSM SHALL use states IDLE -> PLFETCH (1 cycle; pl_addr = req_ptr >> PAGE_SIZE) -> XFER -> DRAIN (1 cycle) -> DONE (toggles ack_toggle[i]) -> IDLE.
REQ-011 In XFER, the block SHALL advance the shm address by 1 per word; on the last word of a page it SHALL jump to pl_rdata << PAGE_SIZE and issue pl_addr for that new page in the same cycle.
REQ-012 LOAD: the block SHALL issue cn_addr in cycle k and write cn_rdata to local address req_local+k in cycle k+1 (pm_we high for exactly req_len cycles).
REQ-013 STORE: the block SHALL issue pm_addr = req_local+k in cycle k and write pm_rdata to the walked shm address in cycle k+1 (cn_we high for exactly req_len cycles).
REQ-014 Throughput SHALL be 1 word/cycle; ack SHALL toggle req_len+3 cycles after the grant cycle.
REQ-015 req_len = 0 SHALL produce no RAM write, with ack toggling 3 cycles after the grant.
REQ-016 Local addresses SHALL wrap modulo 2^LOC_AW.
REQ-017 pm_we of non-granted channels SHALL be 0; re-toggling req_toggle mid-transfer SHALL NOT alter the in-flight transfer.

Reset
REQ-018 On reset, state SHALL be IDLE and ack_toggle, all we outputs, busy, err and all addresses SHALL be 0, effective the next edge, including mid-transfer (the partial transfer is abandoned with no ack).

Configuration
REQ-019 With SHM_DMA_BOUNDS_CHECK_EN defined, a page crossing with pl_rdata == 0 (chain end) SHALL stop writes, set err, and go to DONE (ack toggles); without the macro, page 0 SHALL be followed normally and err SHALL be tied to 0.

Structure
REQ-020 Package shm_dma_pkg SHALL hold the FSM state enum and the READ/WRITE mode constants.
REQ-021 The round-robin arbiter SHALL be the sub-module shm_dma_rr_arb (pending vector in, grant index and valid out, last-served register inside).

Verification
REQ-022 LOAD ch0, ptr=0x02, len=3, page 0 next=5, PAGE_SIZE=2 -> local 0..2 receive shm 0x02, 0x03, 0x14; ack toggles 6 cycles after the grant.
REQ-023 STORE ch2, ptr=0x10, len=4 -> shm 0x10..0x13 hold local data; cn_we high for 4 cycles.
REQ-024 ch1 and ch3 toggled in the same cycle after ch1 was last served -> ch3 is granted first, then ch1.
REQ-025 len=0 on ch1 -> no we pulse; ack toggles 3 cycles after the grant.
REQ-026 Reset asserted in the 2nd XFER cycle -> all we outputs are 0 next cycle, ack_toggle=0, state IDLE.
REQ-027 Macro on, chain end hit on the 2nd page crossing -> err=1, writes stop, ack toggles.

Source files
------------

// File: rtl/shm_dma_pkg.sv
// rtl/shm_dma_pkg.sv - shared types and constants for the shared-memory DMA engine
package shm_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLFETCH,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } dma_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/shm_dma_rr_arb.sv
// rtl/shm_dma_rr_arb.sv - round-robin channel arbiter; search starts after the last-served channel
module shm_dma_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     pending,
  input  logic             advance,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cand;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= IDX_W'(N - 1);
    end else if (advance && grant_valid) begin
      last_q <= grant_idx;
    end
  end

  // Walk offsets from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IDX_W'((int'(last_q) + off) % N);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shm_dma_engine.sv
// rtl/shm_dma_engine.sv - paged shared-memory DMA engine; SHM_DMA_BOUNDS_CHECK_EN enables chain-end detection
module shm_dma_engine
  import shm_dma_pkg::*;
#(
  parameter int PROC_CNT  = 4,
  parameter int SHM_AW    = 8,
  parameter int LOC_AW    = 4,
  parameter int WORD_SIZE = 16,
  parameter int PAGE_SIZE = 2,
  localparam int PAGES_AW = SHM_AW - PAGE_SIZE
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [PROC_CNT-1:0]                 req_toggle,
  input  logic [PROC_CNT-1:0]                 req_write,
  input  logic [PROC_CNT-1:0][SHM_AW-1:0]     req_ptr,
  input  logic [PROC_CNT-1:0][LOC_AW-1:0]     req_local,
  input  logic [PROC_CNT-1:0][LOC_AW:0]       req_len,
  output logic [PROC_CNT-1:0]                 ack_toggle,
  output logic [PROC_CNT-1:0][LOC_AW-1:0]     pm_addr,
  output logic [PROC_CNT-1:0][WORD_SIZE-1:0]  pm_wdata,
  output logic [PROC_CNT-1:0]                 pm_we,
  input  logic [PROC_CNT-1:0][WORD_SIZE-1:0]  pm_rdata,
  output logic [SHM_AW-1:0]                   cn_addr,
  output logic [WORD_SIZE-1:0]                cn_wdata,
  output logic                                cn_we,
  input  logic [WORD_SIZE-1:0]                cn_rdata,
  output logic [PAGES_AW-1:0]                 pl_addr,
  input  logic [PAGES_AW-1:0]                 pl_rdata,
  output logic                                busy,
  output logic                                err
);

  localparam int IDX_W = $clog2(PROC_CNT);
  localparam logic [LOC_AW:0] LEN_ONE = 1;

  dma_state_t            state_q, state_d;
  logic [IDX_W-1:0]      ch_q;
  logic                  write_q;
  logic [LOC_AW-1:0]     local_q;
  logic [SHM_AW-1:0]     addr_q;
  logic [PAGES_AW-1:0]   page_q;
  logic [LOC_AW:0]       cnt_q;
  logic                  wr_valid_q;
  logic [LOC_AW-1:0]     wr_local_q;
  logic [SHM_AW-1:0]     wr_shm_q;
  logic [PROC_CNT-1:0]   ack_q;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  grant_take;
  logic                  last_word;
`ifdef SHM_DMA_BOUNDS_CHECK_EN
  logic                  chain_end;
  logic                  err_q;
`endif

  shm_dma_rr_arb #(
    .N     (PROC_CNT),
    .IDX_W (IDX_W)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .pending     (req_toggle ^ ack_q),
    .advance     (grant_take),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign last_word = &addr_q[PAGE_SIZE-1:0];
`ifdef SHM_DMA_BOUNDS_CHECK_EN
  // A null next-page only matters if more words still need that page.
  assign chain_end = (state_q == ST_XFER) && last_word && (cnt_q > LEN_ONE) && (pl_rdata == '0);
`endif

  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d    = ST_PLFETCH;
          grant_take = 1'b1;
        end
      end
      ST_PLFETCH: state_d = (cnt_q == '0) ? ST_DRAIN : ST_XFER;
      ST_XFER: begin
        if (cnt_q == LEN_ONE) state_d = ST_DRAIN;
`ifdef SHM_DMA_BOUNDS_CHECK_EN
        if (chain_end) state_d = ST_DONE;
`endif
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      write_q    <= MODE_READ;
      local_q    <= '0;
      addr_q     <= '0;
      page_q     <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_local_q <= '0;
      wr_shm_q   <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= (state_q == ST_XFER);
      if (grant_take) begin
        ch_q    <= grant_idx;
        write_q <= req_write[grant_idx];
        local_q <= req_local[grant_idx];
        addr_q  <= req_ptr[grant_idx];
        page_q  <= req_ptr[grant_idx][SHM_AW-1:PAGE_SIZE];
        cnt_q   <= req_len[grant_idx];
      end
      if (state_q == ST_XFER) begin
        wr_local_q <= local_q;
        wr_shm_q   <= addr_q;
        local_q    <= local_q + LOC_AW'(1);
        cnt_q      <= cnt_q - LEN_ONE;
        if (last_word) begin
          addr_q <= {pl_rdata, {PAGE_SIZE{1'b0}}};
          page_q <= pl_rdata;
        end else begin
          addr_q <= addr_q + SHM_AW'(1);
        end
      end
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) ack_q[ch_q] <= ~ack_q[ch_q];
    end
  end

`ifdef SHM_DMA_BOUNDS_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (chain_end) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Read of word k is issued from the walk registers; its write lands one cycle later.
  always_comb begin
    pm_addr  = '0;
    pm_wdata = '0;
    pm_we    = '0;
    cn_addr  = '0;
    cn_wdata = '0;
    cn_we    = 1'b0;
    pl_addr  = page_q;
    if (state_q == ST_XFER) begin
      if (last_word) pl_addr = pl_rdata;
      if (write_q == MODE_WRITE) pm_addr[ch_q] = local_q;
      else cn_addr = addr_q;
    end
    if (wr_valid_q) begin
      if (write_q == MODE_WRITE) begin
        cn_addr  = wr_shm_q;
        cn_wdata = pm_rdata[ch_q];
        cn_we    = 1'b1;
      end else begin
        pm_addr[ch_q]  = wr_local_q;
        pm_wdata[ch_q] = cn_rdata;
        pm_we[ch_q]    = 1'b1;
      end
    end
  end

  assign ack_toggle = ack_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shm_dma_engine.sv
// tb/tb_shm_dma_engine.sv - scoreboard bench for shm_dma_engine with RAM models
module tb_shm_dma_engine;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        req_toggle, req_write;
  logic [3:0][7:0]   req_ptr;
  logic [3:0][3:0]   req_local;
  logic [3:0][4:0]   req_len;
  logic [3:0]        ack_toggle;
  logic [3:0][3:0]   pm_addr;
  logic [3:0][15:0]  pm_wdata;
  logic [3:0]        pm_we;
  logic [3:0][15:0]  pm_rdata;
  logic [7:0]        cn_addr;
  logic [15:0]       cn_wdata;
  logic              cn_we;
  logic [15:0]       cn_rdata;
  logic [5:0]        pl_addr;
  logic [5:0]        pl_rdata;
  logic              busy, err;

  shm_dma_engine dut (
    .clock(clock), .reset(reset), .req_toggle(req_toggle), .req_write(req_write),
    .req_ptr(req_ptr), .req_local(req_local), .req_len(req_len), .ack_toggle(ack_toggle),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_we(pm_we), .pm_rdata(pm_rdata),
    .cn_addr(cn_addr), .cn_wdata(cn_wdata), .cn_we(cn_we), .cn_rdata(cn_rdata),
    .pl_addr(pl_addr), .pl_rdata(pl_rdata), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  logic [15:0] cn_mem [256];
  logic [5:0]  pl_mem [64];
  logic [15:0] lm     [4][16];

  // Content word a holds 0xA000|a; local word a of channel c holds 0x1000*(c+1)+a.
  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) cn_mem[a] <= 16'hA000 | 16'(a);
      for (int p = 0; p < 64; p++) pl_mem[p] <= 6'((p + 1) % 64);
      pl_mem[0] <= 6'd5;
      pl_mem[9] <= 6'd0;
      for (int c = 0; c < 4; c++)
        for (int a = 0; a < 16; a++) lm[c][a] <= 16'(16'h1000 * (c + 1) + a);
    end else begin
      if (cn_we) cn_mem[cn_addr] <= cn_wdata;
      for (int c = 0; c < 4; c++) if (pm_we[c]) lm[c][pm_addr[c]] <= pm_wdata[c];
    end
    cn_rdata <= cn_mem[cn_addr];
    pl_rdata <= pl_mem[pl_addr];
    for (int c = 0; c < 4; c++) pm_rdata[c] <= lm[c][pm_addr[c]];
  end

  typedef struct { int kind; int ch; int addr; int data; } wr_t;
  typedef struct { int ch; int cyc; } ak_t;
  wr_t wq[$];
  ak_t aq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cn_we_cnt = 0;
  int   we_cnt = 0;
  logic ack_mon_en = 1'b0;
  logic [3:0] prev_ack = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic exp_pm(input int ch, input int addr, input int data);
    wq.push_back('{0, ch, addr, data});
  endtask

  task automatic exp_cn(input int addr, input int data);
    wq.push_back('{1, 0, addr, data});
  endtask

  task automatic exp_ack(input int ch, input int at);
    aq.push_back('{ch, at});
  endtask

  task automatic check_write(input int kind, input int ch, input int addr, input int data);
    wr_t e;
    checks++;
    if (wq.size() == 0) begin
      errors++;
      $display("FAIL write_unexpected got kind=%0d ch=%0d addr=%h data=%h required none", kind, ch, addr, data);
    end else begin
      e = wq.pop_front();
      if (e.kind != kind || e.ch != ch || e.addr != addr || e.data != data) begin
        errors++;
        $display("FAIL write got kind=%0d ch=%0d addr=%h data=%h required kind=%0d ch=%0d addr=%h data=%h",
                 kind, ch, addr, data, e.kind, e.ch, e.addr, e.data);
      end
    end
  endtask

  task automatic check_ack(input int ch);
    ak_t e;
    checks++;
    if (aq.size() == 0) begin
      errors++;
      $display("FAIL ack_unexpected got ch=%0d cycle=%0d required none", ch, cyc);
    end else begin
      e = aq.pop_front();
      if (e.ch != ch || e.cyc != cyc) begin
        errors++;
        $display("FAIL ack got ch=%0d cycle=%0d required ch=%0d cycle=%0d", ch, cyc, e.ch, e.cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    if (cn_we === 1'b1) begin
      cn_we_cnt++;
      we_cnt++;
      check_write(1, 0, int'(cn_addr), int'(cn_wdata));
    end
    for (int c = 0; c < 4; c++) begin
      if (pm_we[c] === 1'b1) begin
        we_cnt++;
        check_write(0, c, int'(pm_addr[c]), int'(pm_wdata[c]));
      end
    end
    if (ack_mon_en)
      for (int c = 0; c < 4; c++) if (ack_toggle[c] !== prev_ack[c]) check_ack(c);
    prev_ack = ack_toggle;
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic set_req(input logic [1:0] ch, input logic wr, input logic [7:0] ptr,
                         input logic [3:0] loc, input logic [4:0] len);
    req_write[ch] = wr;
    req_ptr[ch]   = ptr;
    req_local[ch] = loc;
    req_len[ch]   = len;
  endtask

  task automatic issue(input logic [1:0] ch, input logic wr, input logic [7:0] ptr,
                       input logic [3:0] loc, input logic [4:0] len, output int g);
    set_req(ch, wr, ptr, loc, len);
    req_toggle[ch] = ~req_toggle[ch];
    g = cyc;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((wq.size() != 0 || aq.size() != 0 || busy) && n < max);
    if (wq.size() != 0 || aq.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL timeout got pending_writes=%0d pending_acks=%0d busy=%0d required 0 0 0",
               wq.size(), aq.size(), busy);
      wq.delete();
      aq.delete();
    end
  endtask

  int g;
  int base;

  initial begin
    reset = 1'b1;
    req_toggle = '0; req_write = '0; req_ptr = '0; req_local = '0; req_len = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_ack", int'(ack_toggle), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_we", int'({pm_we, cn_we}), 0);
    chk("reset_cn_addr", int'(cn_addr), 0);
    chk("reset_pl_addr", int'(pl_addr), 0);
    ack_mon_en = 1'b1;

    // LOAD ch0 across page 0 -> page 5; fields changed mid-transfer must not matter
    @(posedge clock); #1;
    issue(2'd0, 1'b0, 8'h02, 4'h0, 5'd3, g);
    exp_pm(0, 0, 'hA002); exp_pm(0, 1, 'hA003); exp_pm(0, 2, 'hA014);
    exp_ack(0, g + 6);
    repeat (2) @(posedge clock); #1;
    set_req(2'd0, 1'b1, 8'hFF, 4'h9, 5'd7);
    @(negedge clock);
    chk("busy_mid_xfer", int'(busy), 1);
    wait_done(40);

    // STORE ch2 into 0x10..0x13
    @(posedge clock); #1;
    base = cn_we_cnt;
    issue(2'd2, 1'b1, 8'h10, 4'h5, 5'd4, g);
    exp_cn('h10, 'h3005); exp_cn('h11, 'h3006); exp_cn('h12, 'h3007); exp_cn('h13, 'h3008);
    exp_ack(2, g + 7);
    wait_done(40);
    chk("store_cn_we_cycles", cn_we_cnt - base, 4);

    // Zero-length request on ch1
    @(posedge clock); #1;
    base = we_cnt;
    issue(2'd1, 1'b0, 8'h30, 4'h2, 5'd0, g);
    exp_ack(1, g + 3);
    wait_done(40);
    chk("len0_we_pulses", we_cnt - base, 0);

    // ch1 and ch3 together after ch1 served: ch3 first; both wrap local addresses
    @(posedge clock); #1;
    set_req(2'd1, 1'b1, 8'h50, 4'hE, 5'd3);
    set_req(2'd3, 1'b0, 8'h31, 4'hF, 5'd2);
    req_toggle = req_toggle ^ 4'b1010;
    g = cyc;
    exp_pm(3, 15, 'hA031); exp_pm(3, 0, 'hA032);
    exp_cn('h50, 'h200E); exp_cn('h51, 'h200F); exp_cn('h52, 'h2000);
    exp_ack(3, g + 5);
    exp_ack(1, g + 12);
    wait_done(60);

`ifdef SHM_DMA_BOUNDS_CHECK_EN
    // Page 8 -> 9 -> null: stop after the last word of page 9
    @(posedge clock); #1;
    issue(2'd2, 1'b0, 8'h22, 4'h3, 5'd8, g);
    exp_pm(2, 3, 'hA022); exp_pm(2, 4, 'hA023); exp_pm(2, 5, 'hA024);
    exp_pm(2, 6, 'hA025); exp_pm(2, 7, 'hA026); exp_pm(2, 8, 'hA027);
    exp_ack(2, g + 8);
    wait_done(60);
    chk("chain_end_err", int'(err), 1);
`else
    // Page 9 links to page 0, which is followed like any other page
    @(posedge clock); #1;
    issue(2'd2, 1'b0, 8'h26, 4'h3, 5'd4, g);
    exp_pm(2, 3, 'hA026); exp_pm(2, 4, 'hA027); exp_pm(2, 5, 'hA000); exp_pm(2, 6, 'hA001);
    exp_ack(2, g + 7);
    wait_done(60);
    chk("page0_err", int'(err), 0);
`endif

    // Reset during the second XFER cycle abandons the transfer
    @(posedge clock); #1;
    issue(2'd0, 1'b0, 8'h40, 4'h0, 5'd5, g);
    exp_pm(0, 0, 'hA040);
    repeat (3) @(posedge clock); #1;
    ack_mon_en = 1'b0;
    reset = 1'b1;
    req_toggle = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_pm_we", int'(pm_we), 0);
    chk("rst_mid_cn_we", int'(cn_we), 0);
    chk("rst_mid_ack", int'(ack_toggle), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_err", int'(err), 0);
    chk("rst_mid_pm_addr", int'(pm_addr), 0);
    chk("rst_mid_cn_addr", int'(cn_addr), 0);
    chk("rst_mid_pl_addr", int'(pl_addr), 0);
    repeat (2) @(negedge clock);
    ack_mon_en = 1'b1;
    repeat (6) @(negedge clock);
    chk("scoreboard_empty", wq.size() + aq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
